// File: rtl/data_path.sv
// Bus-based 32-bit datapath: sixteen GPRs, PC, IR, Y, 64-bit Z, HI/LO, MAR, MDR on one
// shared internal bus, plus a combinational ALU. All sequencing is external via strobes.
module data_path (
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        In_Portout,
  input  logic        Cout,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Clock,
  input  logic        clear,
  input  logic        Zin_high,
  input  logic        Zin_low,
  input  logic        HIin,
  input  logic        LOin,
  input  logic [31:0] Mdatain,
  input  logic [3:0]  operation
);

  logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15;
  logic [31:0] PC, IR, Y, ZHI, ZLO, HI, LO, MAR, MDR;
  logic [31:0] bus;

  logic [15:0]       w_rout;
  logic [15:0][31:0] w_gpr;
  logic [31:0]       w_c_sext;
  logic [63:0]       w_alu;
  logic [63:0]       w_prod;
  logic signed [31:0] w_dividend;
  logic signed [31:0] w_divisor;
  logic [31:0]       w_quot;
  logic [31:0]       w_rem;
  logic [4:0]        w_shamt;
  logic [5:0]        w_shinv;
  logic              w_unused;

  assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign w_gpr  = {R15, R14, R13, R12, R11, R10, R9, R8,
                   R7,  R6,  R5,  R4,  R3,  R2,  R1, R0};

  assign w_c_sext = {{13{IR[18]}}, IR[18:0]};

  // MAR and the opcode bits of IR feed memory/control logic outside this block.
  assign w_unused = ^{MAR, IR[31:19]};

  // Bus mux: later assignments win, so sources are applied lowest priority first.
  always_comb begin
    logic [3:0] k;
    bus = '0;
    k   = '0;
    for (int i = 0; i < 16; i++) begin
      k = 4'(15 - i);
      if (w_rout[k]) bus = w_gpr[k];
    end
    if (Cout)       bus = w_c_sext;
    if (In_Portout) bus = '0;
    if (MDRout)     bus = MDR;
    if (LOout)      bus = LO;
    if (HIout)      bus = HI;
    if (Zhighout)   bus = ZHI;
    if (Zlowout)    bus = ZLO;
    if (PCout)      bus = PC;
  end

  assign w_shamt    = bus[4:0];
  assign w_shinv    = 6'd32 - {1'b0, w_shamt};
  assign w_prod     = {{32{Y[31]}}, Y} * {{32{bus[31]}}, bus};
  assign w_dividend = Y;
  assign w_divisor  = bus;

  // The most-negative / -1 quotient is pinned to its two's-complement wrap so the
  // divider never hits the overflow case.
  always_comb begin
    w_quot = '0;
    w_rem  = '0;
    if (bus == 32'd0) begin
      w_quot = '0;
    end else if ((Y == 32'h8000_0000) && (bus == 32'hFFFF_FFFF)) begin
      w_quot = 32'h8000_0000;
    end else begin
      w_quot = w_dividend / w_divisor;
      w_rem  = w_dividend % w_divisor;
    end
  end

  always_comb begin
    w_alu = '0;
    if (IncPC) begin
      w_alu = {32'd0, bus + 32'd1};
    end else begin
      case (operation)
        4'b0001: w_alu = {32'd0, Y + bus};
        4'b0010: w_alu = {32'd0, Y - bus};
        4'b0011: w_alu = {32'd0, Y >> w_shamt};
        4'b0100: w_alu = {32'd0, Y << w_shamt};
        4'b0101: w_alu = {32'd0, (Y >> w_shamt) | (Y << w_shinv)};
        4'b0110: w_alu = {32'd0, (Y << w_shamt) | (Y >> w_shinv)};
        4'b0111: w_alu = {32'd0, Y | bus};
        4'b1000: w_alu = {32'd0, Y & bus};
        4'b1001: w_alu = {32'd0, 32'd0 - bus};
        4'b1010: w_alu = {32'd0, ~bus};
        4'b1011: w_alu = w_prod;
        4'b1100: w_alu = {w_rem, w_quot};
        default: w_alu = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      PC  <= '0;
      IR  <= '0;
      Y   <= '0;
      ZHI <= '0;
      ZLO <= '0;
      HI  <= '0;
      LO  <= '0;
      MAR <= '0;
      MDR <= '0;
    end else begin
      if (PCin)     PC  <= bus;
      if (IRin)     IR  <= bus;
      if (Yin)      Y   <= bus;
      if (HIin)     HI  <= bus;
      if (LOin)     LO  <= bus;
      if (MARin)    MAR <= bus;
      if (MDRin)    MDR <= Read ? Mdatain : bus;
      if (Zin_high) ZHI <= w_alu[63:32];
      if (Zin_low)  ZLO <= w_alu[31:0];
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      R0  <= '0;
      R1  <= '0;
      R2  <= '0;
      R3  <= '0;
      R4  <= '0;
      R5  <= '0;
      R6  <= '0;
      R7  <= '0;
      R8  <= '0;
      R9  <= '0;
      R10 <= '0;
      R11 <= '0;
      R12 <= '0;
      R13 <= '0;
      R14 <= '0;
      R15 <= '0;
    end else begin
      if (R0in)  R0  <= bus;
      if (R1in)  R1  <= bus;
      if (R2in)  R2  <= bus;
      if (R3in)  R3  <= bus;
      if (R4in)  R4  <= bus;
      if (R5in)  R5  <= bus;
      if (R6in)  R6  <= bus;
      if (R7in)  R7  <= bus;
      if (R8in)  R8  <= bus;
      if (R9in)  R9  <= bus;
      if (R10in) R10 <= bus;
      if (R11in) R11 <= bus;
      if (R12in) R12 <= bus;
      if (R13in) R13 <= bus;
      if (R14in) R14 <= bus;
      if (R15in) R15 <= bus;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed and randomized bench for data_path; a behavioural register/ALU model
// supplies every expected value, probed registers are read hierarchically.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        clear;
  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout;
  logic [15:0] rout, rin;
  logic        MARin, PCin, MDRin, IRin, Yin;
  logic        IncPC, Read, Zin_high, Zin_low, HIin, LOin;
  logic [31:0] Mdatain;
  logic [3:0]  operation;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_y, m_zhi, m_zlo, m_hi, m_lo, m_mar, m_mdr;

  always #5 Clock = ~Clock;

  data_path dut (
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
    .LOout(LOout), .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .IncPC(IncPC), .Read(Read),
    .Clock(Clock), .clear(clear), .Zin_high(Zin_high), .Zin_low(Zin_low),
    .HIin(HIin), .LOin(LOin), .Mdatain(Mdatain), .operation(operation)
  );

  function automatic logic [31:0] get_r(input logic [3:0] i);
    case (i)
      4'd0:  return dut.R0;
      4'd1:  return dut.R1;
      4'd2:  return dut.R2;
      4'd3:  return dut.R3;
      4'd4:  return dut.R4;
      4'd5:  return dut.R5;
      4'd6:  return dut.R6;
      4'd7:  return dut.R7;
      4'd8:  return dut.R8;
      4'd9:  return dut.R9;
      4'd10: return dut.R10;
      4'd11: return dut.R11;
      4'd12: return dut.R12;
      4'd13: return dut.R13;
      4'd14: return dut.R14;
      default: return dut.R15;
    endcase
  endfunction

  // Reference ALU: arithmetic on integers, shifts/rotates as repeated single steps.
  function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit inc);
    int ia, ib, sh;
    longint p;
    logic [31:0] r;
    ia = a;
    ib = b;
    sh = int'(b[4:0]);
    r  = '0;
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  begin r = a; repeat (sh) r = r / 32'd2; end
      4'd4:  begin r = a; repeat (sh) r = r * 32'd2; end
      4'd5:  begin r = a; repeat (sh) r = {r[0], r[31:1]}; end
      4'd6:  begin r = a; repeat (sh) r = {r[30:0], r[31]}; end
      4'd7:  r = a | b;
      4'd8:  r = a & b;
      4'd9:  r = 32'd0 - b;
      4'd10: r = 32'hFFFF_FFFF - b;
      4'd11: begin p = longint'(ia) * longint'(ib); return p; end
      4'd12: begin
        if (ib == 0) return 64'd0;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: r = '0;
    endcase
    return {32'h0, r};
  endfunction

  function automatic logic [31:0] c_value(input logic [31:0] ir);
    int v;
    v = int'(ir << 13) >>> 13;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    PCout = 0; Zlowout = 0; Zhighout = 0; HIout = 0; LOout = 0; MDRout = 0;
    In_Portout = 0; Cout = 0; rout = '0; rin = '0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
    IncPC = 0; Read = 0; Zin_high = 0; Zin_low = 0; HIin = 0; LOin = 0;
    operation = 4'd0;
  endtask

  task automatic model_reset();
    foreach (m_r[i]) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_y = '0; m_zhi = '0; m_zlo = '0;
    m_hi = '0; m_lo = '0; m_mar = '0; m_mdr = '0;
  endtask

  task automatic load_reg(input logic [3:0] idx, input logic [31:0] val);
    Mdatain = val; Read = 1; MDRin = 1;
    tick(); idle();
    m_mdr = val;
    MDRout = 1; rin[idx] = 1;
    tick(); idle();
    m_r[idx] = m_mdr;
  endtask

  task automatic alu2(input logic [3:0] rx, input logic [3:0] ry, input logic [3:0] op,
                      input bit zh, input bit zl);
    logic [63:0] res;
    rout[rx] = 1; Yin = 1;
    tick(); idle();
    m_y = m_r[rx];
    rout[ry] = 1; operation = op; Zin_high = zh; Zin_low = zl;
    res = model_alu(op, m_y, m_r[ry], 1'b0);
    tick(); idle();
    if (zh) m_zhi = res[63:32];
    if (zl) m_zlo = res[31:0];
    check($sformatf("zlo_op%0d", op), dut.ZLO, m_zlo);
    check($sformatf("zhi_op%0d", op), dut.ZHI, m_zhi);
  endtask

  task automatic store_z(input logic [3:0] rz);
    Zlowout = 1; rin[rz] = 1;
    tick(); idle();
    m_r[rz] = m_zlo;
    check($sformatf("store_r%0d", rz), get_r(rz), m_r[rz]);
  endtask

  initial begin
    logic [3:0]  rx, ry, rz, op;
    logic [31:0] a, b;
    logic [63:0] res;

    idle();
    Mdatain = '0;
    model_reset();
    clear = 1;
    #12;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_ir", dut.IR, 32'd0);
    check("rst_zlo", dut.ZLO, 32'd0);
    check("rst_zhi", dut.ZHI, 32'd0);
    check("rst_mdr", dut.MDR, 32'd0);
    check("rst_r15", dut.R15, 32'd0);
    check("rst_bus", dut.bus, 32'd0);
    clear = 0;

    // MDR load then transfer to R2
    Mdatain = 32'd12; Read = 1; MDRin = 1;
    tick(); idle();
    check("mdr_load", dut.MDR, 32'd12);
    MDRout = 1; rin[2] = 1;
    #1 check("bus_mdr", dut.bus, 32'd12);
    tick(); idle();
    check("r2_load", dut.R2, 32'd12);
    m_mdr = 32'd12; m_r[2] = 32'd12;

    // AND: 12 & 14
    load_reg(4'd3, 32'd14);
    alu2(4'd2, 4'd3, 4'b1000, 1'b0, 1'b1);
    check("and_zlo", dut.ZLO, 32'd12);
    store_z(4'd1);
    check("and_r1", dut.R1, 32'd12);

    // Instruction fetch
    PCout = 1; MARin = 1; IncPC = 1; Zin_low = 1;
    tick(); idle();
    m_mar = m_pc; m_zlo = m_pc + 32'd1;
    check("fetch_mar", dut.MAR, 32'd0);
    check("fetch_zlo", dut.ZLO, 32'd1);
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2891_8000;
    tick(); idle();
    m_pc = m_zlo; m_mdr = 32'h2891_8000;
    check("fetch_pc", dut.PC, 32'd1);
    check("fetch_mdr", dut.MDR, 32'h2891_8000);
    MDRout = 1; IRin = 1;
    tick(); idle();
    m_ir = m_mdr;
    check("fetch_ir", dut.IR, 32'h2891_8000);
    Cout = 1;
    #1 check("c_pos", dut.bus, c_value(m_ir));
    idle();

    // Negative immediate sign extension
    load_reg(4'd0, 32'h0007_FFFF);
    rout[0] = 1; IRin = 1;
    tick(); idle();
    m_ir = m_r[0];
    Cout = 1;
    #1 check("c_neg", dut.bus, 32'hFFFF_FFFF);
    idle();

    // ADD / SUB wrap
    load_reg(4'd4, 32'hFFFF_FFFF);
    load_reg(4'd5, 32'd1);
    alu2(4'd4, 4'd5, 4'b0001, 1'b1, 1'b1);
    check("add_wrap", dut.ZLO, 32'd0);
    load_reg(4'd6, 32'd12);
    load_reg(4'd7, 32'd14);
    alu2(4'd6, 4'd7, 4'b0010, 1'b1, 1'b1);
    check("sub_wrap", dut.ZLO, 32'hFFFF_FFFE);

    // MUL / DIV
    load_reg(4'd8, 32'hFFFF_FFFD);
    load_reg(4'd9, 32'd5);
    alu2(4'd8, 4'd9, 4'b1011, 1'b1, 1'b1);
    check("mul_hi", dut.ZHI, 32'hFFFF_FFFF);
    check("mul_lo", dut.ZLO, 32'hFFFF_FFF1);
    load_reg(4'd10, 32'd17);
    load_reg(4'd11, 32'd5);
    alu2(4'd10, 4'd11, 4'b1100, 1'b1, 1'b1);
    check("div_q", dut.ZLO, 32'd3);
    check("div_r", dut.ZHI, 32'd2);
    load_reg(4'd12, 32'd0);
    alu2(4'd10, 4'd12, 4'b1100, 1'b1, 1'b1);
    check("div0_lo", dut.ZLO, 32'd0);
    check("div0_hi", dut.ZHI, 32'd0);
    load_reg(4'd13, 32'hFFFF_FFEF);
    alu2(4'd13, 4'd11, 4'b1100, 1'b1, 1'b1);

    // HI / LO
    rout[1] = 1; HIin = 1;
    tick(); idle();
    m_hi = m_r[1];
    check("hi_load", dut.HI, m_hi);
    rout[10] = 1; LOin = 1;
    tick(); idle();
    m_lo = m_r[10];
    check("lo_load", dut.LO, m_lo);
    HIout = 1; rin[14] = 1;
    tick(); idle();
    m_r[14] = m_hi;
    check("hi_to_r14", dut.R14, m_r[14]);

    // Bus priority
    #1 check("bus_none", dut.bus, 32'd0);
    PCout = 1; Zlowout = 1; rout[3] = 1;
    #1 check("prio_pc", dut.bus, m_pc); idle();
    Zlowout = 1; Zhighout = 1; HIout = 1;
    #1 check("prio_zlo", dut.bus, m_zlo); idle();
    Zhighout = 1; HIout = 1; LOout = 1;
    #1 check("prio_zhi", dut.bus, m_zhi); idle();
    HIout = 1; LOout = 1; MDRout = 1;
    #1 check("prio_hi", dut.bus, m_hi); idle();
    LOout = 1; MDRout = 1; Cout = 1;
    #1 check("prio_lo", dut.bus, m_lo); idle();
    MDRout = 1; In_Portout = 1; Cout = 1;
    #1 check("prio_mdr", dut.bus, m_mdr); idle();
    In_Portout = 1; Cout = 1; rout[3] = 1;
    #1 check("prio_inport", dut.bus, 32'd0); idle();
    Cout = 1; rout[0] = 1;
    #1 check("prio_c", dut.bus, c_value(m_ir)); idle();
    rout[5] = 1; rout[3] = 1;
    #1 check("prio_r3", dut.bus, m_r[3]); idle();

    // Same register driving and loading keeps its value
    rout[4] = 1; rin[4] = 1;
    tick(); idle();
    check("self_reload", dut.R4, m_r[4]);

    // IncPC overrides any opcode
    for (int n = 0; n < 6; n++) begin
      rx = 4'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 15));
      rout[rx] = 1; IncPC = 1; operation = op; Zin_high = 1; Zin_low = 1;
      res = model_alu(op, m_y, m_r[rx], 1'b1);
      tick(); idle();
      m_zhi = res[63:32]; m_zlo = res[31:0];
      check("inc_lo", dut.ZLO, m_zlo);
      check("inc_hi", dut.ZHI, m_zhi);
    end

    // Randomized ALU sweep
    for (int n = 0; n < 40; n++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 14));
      if (ry >= rx) ry = ry + 4'd1;
      rz = 4'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (op == 4'd12 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      load_reg(rx, a);
      load_reg(ry, b);
      alu2(rx, ry, op, 1'b1, 1'b1);
      store_z(rz);
    end

    // Asynchronous clear between edges
    load_reg(4'd5, 32'h0000_1234);
    load_reg(4'd6, 32'd7);
    rout[6] = 1; PCin = 1;
    tick(); idle();
    m_pc = m_r[6];
    check("pre_clr_pc", dut.PC, 32'd7);
    check("pre_clr_r5", dut.R5, 32'h0000_1234);
    #2 clear = 1;
    #1;
    model_reset();
    check("clr_pc", dut.PC, 32'd0);
    check("clr_mdr", dut.MDR, 32'd0);
    check("clr_zlo", dut.ZLO, 32'd0);
    check("clr_zhi", dut.ZHI, 32'd0);
    check("clr_y", dut.Y, 32'd0);
    check("clr_hi", dut.HI, 32'd0);
    check("clr_lo", dut.LO, 32'd0);
    check("clr_ir", dut.IR, 32'd0);
    check("clr_mar", dut.MAR, 32'd0);
    check("clr_bus", dut.bus, 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("clr_r%0d", i), get_r(4'(i)), 32'd0);

    // clear wins over a load on the same edge
    Mdatain = 32'h55; Read = 1; MDRin = 1;
    tick(); idle();
    check("clr_prio_mdr", dut.MDR, 32'd0);
    #2 clear = 0;

    load_reg(4'd0, 32'hA5A5_0F0F);
    check("post_clr_r0", dut.R0, 32'hA5A5_0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
